// File: rtl/spi_eeprom_target.sv
// SPI EEPROM-style read target clocked directly by the SPI clock.
// Serves command 0x03 (READ, 24-bit address, streaming auto-increment).
// Optional feature macro SPI_EEPROM_TARGET_STATUS_EN adds IN_status and
// command 0x05 (read status, streamed repeatedly).
module spi_eeprom_target #(
  parameter int unsigned MEM_AW = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IN_cs,
  input  logic        IN_mosi,
  output logic        OUT_miso,
  output logic        OUT_memRe,
  output logic [23:0] OUT_memAddr,
  input  logic [7:0]  IN_memData,
`ifdef SPI_EEPROM_TARGET_STATUS_EN
  input  logic [7:0]  IN_status,
`endif
  output logic        OUT_busy,
  output logic        OUT_cmdErr
);

  localparam int unsigned CNT_W     = 5;
  localparam int unsigned ADDR_BITS = 24;
  localparam logic [7:0]  CMD_READ  = 8'h03;
`ifdef SPI_EEPROM_TARGET_STATUS_EN
  localparam logic [7:0]  CMD_STATUS = 8'h05;
`endif
  localparam logic [23:0] ADDR_MASK = 24'((25'd1 << MEM_AW) - 25'd1);
  localparam logic [CNT_W-1:0] CNT_CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ADDR_WAIT = CNT_W'(ADDR_BITS);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(7);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, TURN, DATA, IGNORE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [22:0]        in_sr_q, in_sr_d;
  logic [7:0]         out_sr_q, out_sr_d;
  logic [23:0]        addr_q, addr_d;
  logic [7:0]         buf_q, buf_d;
  logic               rd_dly_q, rd_dly_d;
  logic               mem_re_q, mem_re_d;
  logic [23:0]        mem_addr_q, mem_addr_d;
  logic               busy_q, busy_d;
  logic               cmd_err_q, cmd_err_d;
  logic               armed_q, armed_d;
  logic               status_mode_q, status_mode_d;

  logic [7:0]         cmd_byte_c;
  logic [23:0]        addr_full_c;
  logic [23:0]        next_addr_c;
  logic [7:0]         stat_byte_c;

  assign cmd_byte_c  = {in_sr_q[6:0], IN_mosi};
  assign addr_full_c = {in_sr_q, IN_mosi} & ADDR_MASK;
  assign next_addr_c = (addr_q + 24'd1) & ADDR_MASK;
`ifdef SPI_EEPROM_TARGET_STATUS_EN
  assign stat_byte_c = IN_status;
`else
  assign stat_byte_c = 8'h00;
`endif

  // Next-state and output decode; chip-select high overrides every state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    in_sr_d       = in_sr_q;
    out_sr_d      = out_sr_q;
    addr_d        = addr_q;
    buf_d         = rd_dly_q ? IN_memData : buf_q;
    rd_dly_d      = mem_re_q;
    mem_re_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    busy_d        = 1'b0;
    cmd_err_d     = 1'b0;
    armed_d       = armed_q;
    status_mode_d = status_mode_q;
    if (IN_cs) begin
      state_d       = IDLE;
      cnt_d         = '0;
      in_sr_d       = '0;
      out_sr_d      = '0;
      armed_d       = 1'b1;
      status_mode_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // After reset a fresh chip-select low edge is required.
          if (armed_q) begin
            in_sr_d = {22'd0, IN_mosi};
            cnt_d   = CNT_W'(1);
            state_d = CMD;
          end
        end
        CMD: begin
          in_sr_d = {in_sr_q[21:0], IN_mosi};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_CMD_LAST) begin
            cnt_d   = '0;
            in_sr_d = '0;
            if (cmd_byte_c == CMD_READ) begin
              state_d = ADDR;
`ifdef SPI_EEPROM_TARGET_STATUS_EN
            end else if (cmd_byte_c == CMD_STATUS) begin
              state_d       = DATA;
              status_mode_d = 1'b1;
              out_sr_d      = stat_byte_c;
              busy_d        = 1'b1;
`endif
            end else begin
              state_d   = IGNORE;
              cmd_err_d = 1'b1;
            end
          end
        end
        ADDR: begin
          // One extra cycle after bit 0 lets the memory respond before TURN.
          if (cnt_q == CNT_ADDR_WAIT) begin
            state_d = TURN;
            busy_d  = 1'b1;
          end else begin
            in_sr_d = {in_sr_q[21:0], IN_mosi};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_ADDR_LAST) begin
              mem_re_d   = 1'b1;
              mem_addr_d = addr_full_c;
              addr_d     = addr_full_c;
            end
          end
        end
        TURN: begin
          state_d  = DATA;
          busy_d   = 1'b1;
          cnt_d    = '0;
          out_sr_d = IN_memData;
        end
        DATA: begin
          busy_d = 1'b1;
          if (cnt_q == CNT_BIT_LAST) begin
            cnt_d    = '0;
            out_sr_d = status_mode_q ? stat_byte_c : buf_q;
          end else begin
            cnt_d    = cnt_q + CNT_W'(1);
            out_sr_d = {out_sr_q[6:0], 1'b0};
            // Prefetch the next byte while bit 6 is on the wire.
            if ((cnt_q == '0) && !status_mode_q) begin
              mem_re_d   = 1'b1;
              addr_d     = next_addr_c;
              mem_addr_d = next_addr_c;
            end
          end
        end
        IGNORE: begin
          state_d = IGNORE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      in_sr_q       <= '0;
      out_sr_q      <= '0;
      addr_q        <= '0;
      buf_q         <= '0;
      rd_dly_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_addr_q    <= '0;
      busy_q        <= 1'b0;
      cmd_err_q     <= 1'b0;
      armed_q       <= 1'b0;
      status_mode_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      in_sr_q       <= in_sr_d;
      out_sr_q      <= out_sr_d;
      addr_q        <= addr_d;
      buf_q         <= buf_d;
      rd_dly_q      <= rd_dly_d;
      mem_re_q      <= mem_re_d;
      mem_addr_q    <= mem_addr_d;
      busy_q        <= busy_d;
      cmd_err_q     <= cmd_err_d;
      armed_q       <= armed_d;
      status_mode_q <= status_mode_d;
    end
  end

  assign OUT_miso    = out_sr_q[7];
  assign OUT_memRe   = mem_re_q;
  assign OUT_memAddr = mem_addr_q;
  assign OUT_busy    = busy_q;
  assign OUT_cmdErr  = cmd_err_q;

endmodule

// File: tb/tb_spi_eeprom_target.sv
// Self-checking bench for spi_eeprom_target: one 24-bit and one 8-bit
// address instance share the serial stimulus; each has its own memory.
module tb_spi_eeprom_target;

`ifdef SPI_EEPROM_TARGET_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  typedef struct packed {
    logic        miso;
    logic        re;
    logic [23:0] addr;
    logic        busy;
    logic        err;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst, cs, mosi;
  logic        miso_a, re_a, busy_a, err_a;
  logic [23:0] addr_a;
  logic [7:0]  mdata_a;
  logic        miso_b, re_b, busy_b, err_b;
  logic [23:0] addr_b;
  logic [7:0]  mdata_b;
`ifdef SPI_EEPROM_TARGET_STATUS_EN
  logic [7:0]  status_v;
`endif
  logic [7:0]  salt = 8'h00;
  int          vectors = 0;
  int          errors  = 0;

  always #5 clk = ~clk;

  spi_eeprom_target dut (
    .clk(clk), .rst(rst), .IN_cs(cs), .IN_mosi(mosi),
    .OUT_miso(miso_a), .OUT_memRe(re_a), .OUT_memAddr(addr_a),
    .IN_memData(mdata_a),
`ifdef SPI_EEPROM_TARGET_STATUS_EN
    .IN_status(status_v),
`endif
    .OUT_busy(busy_a), .OUT_cmdErr(err_a)
  );

  spi_eeprom_target #(.MEM_AW(8)) dut8 (
    .clk(clk), .rst(rst), .IN_cs(cs), .IN_mosi(mosi),
    .OUT_miso(miso_b), .OUT_memRe(re_b), .OUT_memAddr(addr_b),
    .IN_memData(mdata_b),
`ifdef SPI_EEPROM_TARGET_STATUS_EN
    .IN_status(status_v),
`endif
    .OUT_busy(busy_b), .OUT_cmdErr(err_b)
  );

  // Memory contents as a pure function of address; salt 0 gives memory[n]=n for n<256.
  function automatic logic [7:0] mem_f(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ salt;
  endfunction

  // Synchronous memories: data valid only in the cycle after the request.
  always @(posedge clk) begin
    mdata_a <= re_a ? mem_f(addr_a) : 8'($urandom);
    mdata_b <= re_b ? mem_f(addr_b) : 8'($urandom);
  end

  // Expected outputs i cycles after the first command bit, from the protocol rules.
  function automatic obs_t expect_at(input int i, input logic [7:0] cmd, input logic [23:0] addr,
                                     input int aw, input logic [7:0] stat);
    obs_t        e;
    logic [23:0] mask;
    logic [23:0] a0;
    logic [7:0]  cur;
    int          k;
    e    = '0;
    mask = 24'((25'd1 << aw) - 25'd1);
    a0   = addr & mask;
    if (cmd == 8'h03) begin
      if (i == 31) begin
        e.re   = 1'b1;
        e.addr = a0;
      end
      if (i >= 34 && ((i - 34) % 8) == 0) begin
        e.re   = 1'b1;
        e.addr = (a0 + 24'((i - 34) / 8 + 1)) & mask;
      end
      if (i >= 32) e.busy = 1'b1;
      if (i >= 33) begin
        k      = i - 33;
        cur    = mem_f((a0 + 24'(k / 8)) & mask);
        e.miso = cur[7 - (k % 8)];
      end
    end else if (STATUS_EN && cmd == 8'h05) begin
      if (i >= 7) begin
        e.busy = 1'b1;
        e.miso = stat[7 - ((i - 7) % 8)];
      end
    end else if (i == 7) begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  // Drive a transaction for ncyc cycles with chip select low, checking every cycle.
  task automatic run_txn(input string tag, input logic [7:0] cmd, input logic [23:0] addr,
                         input int ncyc, input logic [7:0] stat);
    obs_t ea, eb, oa, ob;
`ifdef SPI_EEPROM_TARGET_STATUS_EN
    status_v = stat;
`endif
    for (int i = 0; i < ncyc; i++) begin
      cs = 1'b0;
      if (i < 8)       mosi = cmd[7 - i];
      else if (i < 32) mosi = addr[31 - i];
      else             mosi = 1'($urandom);
      @(negedge clk);
      ea = expect_at(i, cmd, addr, 24, stat);
      eb = expect_at(i, cmd, addr, 8, stat);
      oa = {miso_a, re_a, (re_a ? addr_a : 24'd0), busy_a, err_a};
      ob = {miso_b, re_b, (re_b ? addr_b : 24'd0), busy_b, err_b};
      vectors++;
      if (oa !== ea) begin
        errors++;
        $display("FAIL %s aw24 cyc %0d got %h exp %h", tag, i, oa, ea);
      end
      vectors++;
      if (ob !== eb) begin
        errors++;
        $display("FAIL %s aw8 cyc %0d got %h exp %h", tag, i, ob, eb);
      end
    end
  endtask

  // Raise chip select for one cycle; both targets must go quiet on that edge.
  task automatic end_txn(input string tag);
    cs   = 1'b1;
    mosi = 1'($urandom);
    @(negedge clk);
    vectors++;
    if ({miso_a, re_a, busy_a, err_a, miso_b, re_b, busy_b, err_b} !== 8'h00) begin
      errors++;
      $display("FAIL %s_cs_high got %b%b%b%b %b%b%b%b exp 0000 0000", tag,
               miso_a, re_a, busy_a, err_a, miso_b, re_b, busy_b, err_b);
    end
  endtask

  task automatic check_quiet(input string tag);
    vectors++;
    if ({miso_a, re_a, busy_a, err_a, addr_a, miso_b, re_b, busy_b, err_b, addr_b} !== 56'd0) begin
      errors++;
      $display("FAIL %s got a=%b%b%b%b/%h b=%b%b%b%b/%h exp all zero", tag,
               miso_a, re_a, busy_a, err_a, addr_a, miso_b, re_b, busy_b, err_b, addr_b);
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    cs   = 1'b0;
    mosi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mosi = ~mosi;
      @(negedge clk);
      check_quiet("reset");
    end
    rst = 1'b0;
    // Chip select still low from before reset: no transaction may start.
    for (int i = 0; i < 40; i++) begin
      mosi = (i < 8) ? ((8'h03 >> (7 - i)) & 8'h01) != 0 : 1'($urandom);
      @(negedge clk);
      check_quiet("post_reset_cs_low");
    end
    end_txn("reset");
  endtask

  task automatic test_read_basic();
    salt = 8'h00;
    run_txn("read_0x10", 8'h03, 24'h000010, 33 + 24, 8'h00);
    end_txn("read_0x10");
  endtask

  task automatic test_wrap();
    salt = 8'h00;
    run_txn("wrap_ffffff", 8'h03, 24'hFFFFFF, 33 + 16, 8'h00);
    end_txn("wrap_ffffff");
    run_txn("wrap_fe", 8'h03, 24'h0000FE, 33 + 24, 8'h00);
    end_txn("wrap_fe");
  endtask

  task automatic test_cmd_err();
    salt = 8'($urandom);
    run_txn("cmd_ab", 8'hAB, 24'($urandom), 20, 8'h00);
    end_txn("cmd_ab");
    run_txn("after_ab", 8'h03, 24'($urandom), 33 + 16, 8'h00);
    end_txn("after_ab");
  endtask

  task automatic test_abort();
    salt = 8'($urandom);
    run_txn("abort", 8'h03, 24'($urandom), 33 + 8 + 5, 8'h00);
    end_txn("abort");
    salt = 8'h00;
    run_txn("after_abort", 8'h03, 24'h000040, 33 + 8, 8'h00);
    end_txn("after_abort");
  endtask

  task automatic test_reset_midway();
    salt = 8'($urandom);
    run_txn("pre_rst", 8'h03, 24'($urandom), 38, 8'h00);
    rst = 1'b1;
    cs  = 1'b0;
    @(negedge clk);
    check_quiet("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mosi = 1'($urandom);
      @(negedge clk);
      check_quiet("mid_rst_cs_low");
    end
    end_txn("mid_rst");
    run_txn("after_mid_rst", 8'h03, 24'($urandom), 33 + 16, 8'h00);
    end_txn("after_mid_rst");
  endtask

  task automatic test_status();
    salt = 8'($urandom);
    run_txn("status", 8'h05, 24'($urandom), 7 + 16, 8'hA5);
    end_txn("status");
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    int         kind;
    for (int n = 0; n < 12; n++) begin
      salt = 8'($urandom);
      kind = int'($urandom_range(0, 2));
      if (kind == 0) begin
        run_txn("rand_read", 8'h03, 24'($urandom), 33 + 8 * int'($urandom_range(1, 4)), 8'h00);
      end else if (kind == 1) begin
        cmd = 8'($urandom);
        while (cmd == 8'h03 || (STATUS_EN && cmd == 8'h05)) cmd = 8'($urandom);
        run_txn("rand_badcmd", cmd, 24'($urandom), 8 + int'($urandom_range(0, 6)), 8'h00);
      end else begin
        run_txn("rand_status", 8'h05, 24'($urandom), 7 + 8 * int'($urandom_range(1, 3)),
                8'($urandom));
      end
      end_txn("rand");
    end
  endtask

  task automatic test_back_to_back();
    salt = 8'($urandom);
    run_txn("b2b_first", 8'h03, 24'($urandom), 33 + 16, 8'h00);
    end_txn("b2b_first");
    run_txn("b2b_second", 8'h03, 24'($urandom), 33 + 16, 8'h00);
    end_txn("b2b_second");
  endtask

  initial begin
    rst  = 1'b1;
    cs   = 1'b1;
    mosi = 1'b0;
`ifdef SPI_EEPROM_TARGET_STATUS_EN
    status_v = 8'h00;
`endif
    test_reset();
    test_read_basic();
    test_wrap();
    test_cmd_err();
    test_abort();
    test_reset_midway();
    test_status();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
